// File: rtl/peri_bus_master_if.sv
// Request/response and peripheral-bus signals of peri_bus_master.
// master is the block's view; slave is the MEM stage plus the peripheral side.
interface peri_bus_master_if;
  logic        req_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_ready_o;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        peri_cre_o;
  logic        peri_cwe_o;
  logic [31:0] peri_addr_o;
  logic [31:0] peri_wdata_o;
  logic [31:0] peri_rdata_i;

  modport master (
    input  req_i, req_we_i, req_addr_i, req_wdata_i, peri_rdata_i,
    output req_ready_o, stall_o, resp_valid_o, resp_rdata_o, resp_err_o,
           peri_cre_o, peri_cwe_o, peri_addr_o, peri_wdata_o
  );

  modport slave (
    output req_i, req_we_i, req_addr_i, req_wdata_i, peri_rdata_i,
    input  req_ready_o, stall_o, resp_valid_o, resp_rdata_o, resp_err_o,
           peri_cre_o, peri_cwe_o, peri_addr_o, peri_wdata_o
  );
endinterface

// File: rtl/peri_bus_master.sv
// Peripheral bus initiator: decodes one MEM-stage load/store, strobes the bus
// for WAIT_CYCLES+1 cycles, then returns a one-cycle response.
module peri_bus_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned NUM_REGS    = 6,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst,
  peri_bus_master_if.master bus
);

  localparam int unsigned      CNT_W    = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  // 33-bit bounds so the top of the window cannot wrap past 2^32
  localparam logic [32:0]      ADDR_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0]      ADDR_HI  = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS) - 33'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             cre_q, cre_d;
  logic             cwe_q, cwe_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [32:0] req_addr_ext;
  logic        req_ok;

  assign req_addr_ext = {1'b0, bus.req_addr_i};
  assign req_ok = (req_addr_ext >= ADDR_LO) && (req_addr_ext <= ADDR_HI) &&
                  (bus.req_addr_i[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      cre_q    <= 1'b0;
      cwe_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      cre_q    <= cre_d;
      cwe_q    <= cwe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Registered outputs are computed for the state being entered, so strobes
  // line up with ACCESS and the response with RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    cre_d    = 1'b0;
    cwe_d    = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d = bus.req_we_i;
          if (req_ok) begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = bus.req_addr_i;
            wdata_d = bus.req_wdata_i;
            cre_d   = !bus.req_we_i;
            cwe_d   = bus.req_we_i && (CNT_LAST == '0);
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          cnt_d    = '0;
          rvalid_d = 1'b1;
          if (!we_q) rdata_d = bus.peri_rdata_i;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          addr_d  = addr_q;
          wdata_d = wdata_q;
          cre_d   = !we_q;
          cwe_d   = we_q && (cnt_d == CNT_LAST);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.stall_o      = ((state_q == IDLE) && bus.req_i) || (state_q == ACCESS);
  assign bus.resp_valid_o = rvalid_q;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.peri_cre_o   = cre_q;
  assign bus.peri_cwe_o   = cwe_q;
  assign bus.peri_addr_o  = addr_q;
  assign bus.peri_wdata_o = wdata_q;

endmodule

// File: doc/peri_bus_master.md
Name: peri_bus_master

Overview:
- Initiator side of the memory-mapped peripheral bus (cre/cwe/addr/wdata/rdata) used by the timer/LED/digit/systick register block at 0x4000_0000.
- Sits between the MEM stage and the peripheral bus.
- Accepts one load/store request at a time, range- and alignment-checks it, and drives the bus strobes for a configurable number of wait states.
- Returns read data or an error, and stalls the pipeline until the access completes.

Parameters:
- BASE_ADDR, 32'h4000_0000, first peripheral register address.
- NUM_REGS, 6, number of 32-bit word registers mapped from BASE_ADDR.
- WAIT_CYCLES, 0, extra cycles the bus strobes are held before read data is sampled or the write is committed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  MEM-stage peripheral request; held high until resp_valid_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- req_ready_o  out  1  block is IDLE and will accept a request.
- stall_o  out  1  freeze the pipeline.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  load data; 0 for stores and errors.
- resp_err_o  out  1  qualifies resp_valid_o; address out of range or misaligned.
- peri_cre_o  out  1  peripheral read enable.
- peri_cwe_o  out  1  peripheral write enable.
- peri_addr_o  out  32  peripheral address.
- peri_wdata_o  out  32  peripheral write data.
- peri_rdata_i  in  32  peripheral read data; combinational from peri_addr_o/peri_cre_o.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE and wait counter to 0. All registered outputs go to 0 immediately: cre, cwe, addr, wdata, resp_valid, rdata, err. An access in flight is abandoned and no write is issued. req_ready_o=1 after release.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready_o=1.
  - If req_i=1, latch we/addr/wdata and decode. The request is valid iff BASE_ADDR <= addr <= BASE_ADDR+4*NUM_REGS-4 and addr[1:0]==0.
  - Valid request: go to ACCESS with counter=0.
  - Invalid request: go to RESP with err=1. No bus strobe is ever asserted.
- ACCESS:
  - Lasts WAIT_CYCLES+1 cycles.
  - peri_addr_o and peri_wdata_o hold the latched values.
  - Load: peri_cre_o=1 for every ACCESS cycle. peri_rdata_i is registered into resp_rdata_o on the last ACCESS cycle.
  - Store: peri_cwe_o=1 only in the last ACCESS cycle, so exactly one write per store. peri_cre_o=0.
  - Counter increments each cycle. On counter==WAIT_CYCLES go to RESP.
  - Counter width is max(1, clog2(WAIT_CYCLES+1)).
- RESP:
  - resp_valid_o=1 for exactly one cycle. resp_err_o per decode. resp_rdata_o=sampled data for loads, 0 otherwise.
  - Strobes are 0. Next state is IDLE.
  - req_i in this cycle belongs to the finishing instruction and is ignored.
- Strobes and peri_addr_o/peri_wdata_o are 0 outside ACCESS.
- stall_o = (IDLE & req_i) | ACCESS; it is 0 in RESP so the pipeline advances on that edge.
- Latency, request seen to resp_valid_o, in cycles: 2+WAIT_CYCLES for valid accesses, 1 for errors. Back-to-back requests therefore cost an extra idle cycle each (3+WAIT_CYCLES cycles per valid request).
- Requests arriving outside IDLE are ignored; the requester must hold its request stable.
- Address wrap: the range check uses 33-bit arithmetic, so the upper bound never wraps.

Test Plan:
- Load, WAIT_CYCLES=0, addr 0x4000_0014, peri_rdata_i=0x0000_1234 -> cre high cycle 1 only; resp_valid cycle 2; rdata=0x1234; err=0; stall high cycles 0-1.
- Store, WAIT_CYCLES=2, addr 0x4000_000C, wdata 0xA5 -> cre never high; cwe high exactly one cycle (cycle 3) with addr 0x4000_000C and wdata 0xA5; resp_valid cycle 4; rdata=0.
- Error addresses 0x4000_0018, 0x4000_0002 and 0x3FFF_FFFC -> no strobes; resp_valid with err=1 the cycle after request; rdata=0.
- Back-to-back loads 0x4000_0000 then 0x4000_0004 -> two distinct resp_valid pulses with correct data; no duplicate strobes; req_ready low in ACCESS/RESP.
- rst pulsed low mid-ACCESS of a store with WAIT_CYCLES=3 -> all outputs 0 asynchronously; cwe never asserted; after release a fresh load completes normally.
- Request held high during RESP -> no second access is launched for the same instruction.
